// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receiver: locks byte alignment on COM characters, then delivers bytes.
// Optional RX_BYTE_COUNT_EN adds a saturating count of delivered data bytes.
module serial_paralelo_rx #(
  parameter logic [7:0]  COM     = 8'hBC,
  parameter logic [7:0]  IDLE    = 8'h7C,
  parameter int unsigned BC_LOCK = 4
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic        data_in,
  output logic [7:0]  data_out,
  output logic        valid_out,
  output logic        active,
  output logic        IDLE_OUT
`ifdef RX_BYTE_COUNT_EN
  ,
  output logic [15:0] byte_count
`endif
);

  localparam logic [3:0] LOCK_N = 4'(BC_LOCK);

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_ALIGN  = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  sr_q;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  bc_cnt_q, bc_cnt_d;
  logic [7:0]  data_d;
  logic        valid_d, active_d, idle_d;
  logic        take_byte;
  logic [7:0]  win;
  logic        boundary;

  // Only the 7 most recent bits are stored; the 8th is the bit being sampled.
  assign win      = {sr_q, data_in};
  assign boundary = (bit_cnt_q == 3'd7);

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_q   <= S_SEARCH;
      sr_q      <= 7'd0;
      bit_cnt_q <= 3'd0;
      bc_cnt_q  <= 4'd0;
      data_out  <= 8'h00;
      valid_out <= 1'b0;
      active    <= 1'b0;
      IDLE_OUT  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= win[6:0];
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q  <= bc_cnt_d;
      data_out  <= data_d;
      valid_out <= valid_d;
      active    <= active_d;
      IDLE_OUT  <= idle_d;
    end
  end

  // Alignment FSM and per-byte output decode.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q + 3'd1;
    bc_cnt_d  = bc_cnt_q;
    data_d    = data_out;
    valid_d   = valid_out;
    active_d  = active;
    idle_d    = IDLE_OUT;
    take_byte = 1'b0;
    case (state_q)
      S_SEARCH: begin
        bit_cnt_d = 3'd0;
        valid_d   = 1'b0;
        idle_d    = 1'b0;
        if (win == COM) begin
          bc_cnt_d = 4'd1;
          if (LOCK_N == 4'd1) begin
            state_d  = S_ACTIVE;
            active_d = 1'b1;
          end else begin
            state_d = S_ALIGN;
          end
        end
      end
      S_ALIGN: begin
        if (boundary) begin
          if (win == COM) begin
            bc_cnt_d = bc_cnt_q + 4'd1;
            if (bc_cnt_d == LOCK_N) begin
              state_d  = S_ACTIVE;
              active_d = 1'b1;
            end
          end else begin
            state_d  = S_SEARCH;
            bc_cnt_d = 4'd0;
          end
        end
      end
      S_ACTIVE: begin
        if (boundary) begin
          if (win == COM) begin
            valid_d = 1'b0;
          end else if (win == IDLE) begin
            valid_d = 1'b0;
            idle_d  = 1'b1;
          end else begin
            data_d    = win;
            valid_d   = 1'b1;
            idle_d    = 1'b0;
            take_byte = 1'b1;
          end
        end
      end
      default: state_d = S_SEARCH;
    endcase
  end

`ifdef RX_BYTE_COUNT_EN
  // Saturating count of delivered data bytes.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      byte_count <= 16'h0000;
    end else if (take_byte && (byte_count != 16'hFFFF)) begin
      byte_count <= byte_count + 16'd1;
    end
  end
`else
  logic unused_take;
  assign unused_take = take_byte;
`endif

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Bench for serial_paralelo_rx: bit-history model compared every cycle plus directed literal checks.
module tb_serial_paralelo_rx;

  localparam logic [7:0] COM     = 8'hBC;
  localparam logic [7:0] IDLE    = 8'h7C;
  localparam int         BC_LOCK = 4;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b0;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out, active, IDLE_OUT;
`ifdef RX_BYTE_COUNT_EN
  logic [15:0] byte_count;
  logic [15:0] exp_cnt = 16'h0000;
`endif

  int checks = 0;
  int errors = 0;

  serial_paralelo_rx #(.COM(COM), .IDLE(IDLE), .BC_LOCK(BC_LOCK)) dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .active    (active),
    .IDLE_OUT  (IDLE_OUT)
`ifdef RX_BYTE_COUNT_EN
    ,
    .byte_count(byte_count)
`endif
  );

  always #5 clk_32f = ~clk_32f;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: tracks the 8-bit history, an alignment anchor phase and a COM run length.
  logic [7:0] hist8     = 8'h00;
  int         m_mode    = 0;   // 0 hunting, 1 counting COMs, 2 locked
  int         m_run     = 0;
  int         m_phase   = 0;
  logic [7:0] exp_data  = 8'h00;
  logic       exp_valid = 1'b0;
  logic       exp_act   = 1'b0;
  logic       exp_idle  = 1'b0;

  always @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      hist8 = 8'h00; m_mode = 0; m_run = 0; m_phase = 0;
      exp_data = 8'h00; exp_valid = 1'b0; exp_act = 1'b0; exp_idle = 1'b0;
`ifdef RX_BYTE_COUNT_EN
      exp_cnt = 16'h0000;
`endif
    end else begin
      hist8   = {hist8[6:0], data_in};
      m_phase = (m_phase + 1) % 8;
      if (m_mode == 0) begin
        if (hist8 == COM) begin
          m_phase = 0;
          m_run   = 1;
          m_mode  = (BC_LOCK == 1) ? 2 : 1;
        end
      end else if (m_phase == 0) begin
        if (m_mode == 1) begin
          if (hist8 == COM) begin
            m_run++;
            if (m_run == BC_LOCK) m_mode = 2;
          end else begin
            m_mode = 0;
            m_run  = 0;
          end
        end else begin
          if (hist8 == COM) begin
            exp_valid = 1'b0;
          end else if (hist8 == IDLE) begin
            exp_valid = 1'b0;
            exp_idle  = 1'b1;
          end else begin
            exp_data  = hist8;
            exp_valid = 1'b1;
            exp_idle  = 1'b0;
`ifdef RX_BYTE_COUNT_EN
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
`endif
          end
        end
      end
      exp_act = (m_mode == 2);
    end
  end

  // Cycle-by-cycle comparison, away from the active edge.
  always @(negedge clk_32f) begin
    chk("data_out",  16'(data_out),  16'(exp_data));
    chk("valid_out", 16'(valid_out), 16'(exp_valid));
    chk("active",    16'(active),    16'(exp_act));
    chk("IDLE_OUT",  16'(IDLE_OUT),  16'(exp_idle));
`ifdef RX_BYTE_COUNT_EN
    chk("byte_count", byte_count, exp_cnt);
`endif
  end

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      data_in = b[i];
      @(negedge clk_32f);
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      data_in = b[i];
      @(negedge clk_32f);
    end
  endtask

  task automatic idle_bits(input int n);
    data_in = 1'b0;
    repeat (n) @(negedge clk_32f);
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    repeat (2) @(negedge clk_32f);
    reset   = 1'b1;
    data_in = 1'b0;
    repeat (2) @(negedge clk_32f);
  endtask

  task automatic send_coms(input int n);
    for (int k = 0; k < n; k++) send_byte(COM);
  endtask

  initial begin
    // Reset held while the line toggles.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_32f);
      data_in = ~data_in;
    end
    chk("rst_data",   16'(data_out),  16'h0000);
    chk("rst_active", 16'(active),    16'h0000);
    chk("rst_valid",  16'(valid_out), 16'h0000);
    @(negedge clk_32f);
    reset = 1'b1;
    idle_bits(5);

    // Clean lock.
    send_coms(3);
    chk("lock_not_yet", 16'(active), 16'h0000);
    send_byte(COM);
    chk("lock_4th_com", 16'(active), 16'h0001);
    chk("lock_no_valid", 16'(valid_out), 16'h0000);
    send_byte(8'hFF);
    chk("byte_ff", 16'(data_out), 16'h00FF);
    chk("valid_ff", 16'(valid_out), 16'h0001);
    send_byte(8'hEE);
    chk("byte_ee", 16'(data_out), 16'h00EE);
    send_byte(8'hDD);
    chk("byte_dd", 16'(data_out), 16'h00DD);
    send_byte(8'hCC);
    chk("byte_cc", 16'(data_out), 16'h00CC);

    // Control characters while locked.
    send_byte(IDLE);
    chk("idle_flag", 16'(IDLE_OUT), 16'h0001);
    chk("idle_valid", 16'(valid_out), 16'h0000);
    chk("idle_hold", 16'(data_out), 16'h00CC);
    send_byte(COM);
    chk("com_idle_hold", 16'(IDLE_OUT), 16'h0001);
    chk("com_data_hold", 16'(data_out), 16'h00CC);
    send_byte(8'h77);
    chk("after77_idle", 16'(IDLE_OUT), 16'h0000);
    chk("after77_valid", 16'(valid_out), 16'h0001);
    chk("after77_data", 16'(data_out), 16'h0077);

    // Misaligned lock.
    do_reset();
    send_bits(8'hA0, 3);
    send_coms(4);
    chk("mis_active", 16'(active), 16'h0001);
    send_byte(8'h99);
    chk("mis_data", 16'(data_out), 16'h0099);
    chk("mis_valid", 16'(valid_out), 16'h0001);

    // Broken alignment.
    do_reset();
    send_coms(3);
    send_byte(8'h55);
    chk("brk_active", 16'(active), 16'h0000);
    chk("brk_valid", 16'(valid_out), 16'h0000);
    send_coms(3);
    chk("brk_3rd", 16'(active), 16'h0000);
    send_byte(COM);
    chk("brk_relock", 16'(active), 16'h0001);
    send_byte(8'h11);
    chk("brk_data", 16'(data_out), 16'h0011);

    // Mid-byte asynchronous reset, then relock.
    send_bits(8'hA5, 4);
    #3 reset = 1'b0;
    #1;
    chk("mid_data", 16'(data_out), 16'h0000);
    chk("mid_valid", 16'(valid_out), 16'h0000);
    chk("mid_active", 16'(active), 16'h0000);
`ifdef RX_BYTE_COUNT_EN
    chk("mid_count", byte_count, 16'h0000);
`endif
    repeat (3) @(negedge clk_32f);
    reset = 1'b1;
    idle_bits(3);
    send_coms(4);
    for (int k = 1; k <= 5; k++) send_byte(8'(k));
    chk("relock_data", 16'(data_out), 16'h0005);
    chk("relock_valid", 16'(valid_out), 16'h0001);
`ifdef RX_BYTE_COUNT_EN
    chk("count_5", byte_count, 16'h0005);
`endif
    send_byte(COM);
    chk("filler_valid", 16'(valid_out), 16'h0000);
    chk("filler_hold", 16'(data_out), 16'h0005);
    idle_bits(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_paralelo_rx.md
# serial_paralelo_rx

Receive-side deserializer that closes the physical-layer loop behind the four-lane MUX L1/L2 chain. It takes the single-bit serial stream produced by the transmit serializer, finds the byte boundary by locking onto COM (0xBC) characters, and delivers one 8-bit byte per eight clocks with a valid flag. It also delivers the `active` and `IDLE_OUT` status that the lane-level bench uses to decide when link bring-up is finished.

## Interface

Parameters:
- `COM`, 8'hBC, comma/filler character used for alignment and for "no valid data".
- `IDLE`, 8'h7C, idle character; signals that the link is up but the transmitter is idle.
- `BC_LOCK`, 4, number of consecutive aligned COM bytes required to declare the link active; legal range 1..15.

Ports:
- `clk_32f`, input, 1, serial bit clock (8x `clk_4f`); all logic on posedge.
- `reset`, input, 1, asynchronous, active-low; `reset`=0 forces the reset state immediately.
- `data_in`, input, 1, serial bit, MSB first.
- `data_out`, output, 8, last received data byte; registered.
- `valid_out`, output, 1, `data_out` carries a data byte this byte period.
- `active`, output, 1, link aligned and locked.
- `IDLE_OUT`, output, 1, last non-COM character received while active was IDLE.
- `byte_count`, output, 16, present only with `RX_BYTE_COUNT_EN`; see Configuration.

## Operation

- Shift register: `sr <= {sr[6:0], data_in}` on every edge. The candidate byte is `win = {sr[6:0], data_in}`, the 8 most recent bits including the one being sampled.
- 3-bit `bit_cnt` marks byte boundaries once aligned. A boundary edge is an edge where `bit_cnt`==7. `bit_cnt` wraps 7 -> 0.
- 4-bit `bc_cnt` counts aligned COMs.
- State machine, registered:
  - SEARCH (reset state):
    - Compares `win` against `COM` on every edge.
    - On a match: go to ALIGN, or straight to ACTIVE if `BC_LOCK`==1. Set `bit_cnt` to 0 and `bc_cnt` to 1.
  - ALIGN: acts only on boundary edges.
    - `win`==`COM`: `bc_cnt`+1. When the new count equals `BC_LOCK`, go to ACTIVE and set `active` to 1 on that same edge.
    - Any other byte: go to SEARCH and clear `bc_cnt`.
  - ACTIVE: acts only on boundary edges. It is left only by reset; there is no loss-of-lock detection.
    - `win`==`COM`: `valid_out` 0; `data_out` and `IDLE_OUT` hold.
    - `win`==`IDLE`: `valid_out` 0; `IDLE_OUT` 1; `data_out` holds.
    - Any other byte: `data_out`=`win`; `valid_out` 1; `IDLE_OUT` 0.
- Data bytes equal to 0xBC or 0x7C cannot be distinguished from control characters. The transmitter never sends them as data.
- Outside ACTIVE: `valid_out` and `IDLE_OUT` stay 0 and `data_out` holds.

## Timing

- Reset values: `data_out` 8'h00, `valid_out` 0, `active` 0, `IDLE_OUT` 0, `byte_count` 16'h0000, state SEARCH, `sr` 0, `bit_cnt` 0, `bc_cnt` 0.
- Latency: outputs update on the same edge that samples bit 0 (LSB) of the byte. They are stable for the following 8 edges.
- `valid_out` and `IDLE_OUT` are per-byte-period levels, not one-cycle pulses.
- The first payload byte after lock is the byte that starts on the edge after the `BC_LOCK`-th COM.
- Deasserting reset mid-byte restarts the search from an empty shift register. Stale partial bits are never emitted.
- Extra COMs after lock are treated as filler and cause no realignment.

## Configuration

- `RX_BYTE_COUNT_EN`:
  - Defined: adds the `byte_count` output port. It increments on every boundary edge that sets `valid_out` to 1, saturates at 16'hFFFF, and is cleared only by reset.
  - Undefined: the port and the counter do not exist; all other behaviour is identical.

## Test plan

- Reset: hold `reset`=0 for 20 cycles while `data_in` toggles -> all outputs at their reset values throughout; no lock.
- Clean lock: 4x 0xBC, then 0xFF, 0xEE, 0xDD, 0xCC -> `active`=1 on the edge sampling the LSB of the 4th COM. Then `data_out` = FF, EE, DD, CC with `valid_out`=1 on consecutive byte boundaries, 8 cycles apart.
- Misaligned lock: 3 random bits, then 4x 0xBC, then 0x99 -> lock achieved anyway; `data_out`=0x99 with `valid_out`=1.
- Broken alignment: 3x 0xBC, 0x55, then 4x 0xBC, then 0x11 -> `active` stays 0 through the 0x55 and asserts only after the second run of COMs; `data_out`=0x11.
- Control characters while active: 0x7C, 0xBC, 0x77 -> after 0x7C, `IDLE_OUT`=1 and `valid_out`=0. After 0xBC, `IDLE_OUT` stays 1 and `data_out` holds. After 0x77, `IDLE_OUT`=0, `valid_out`=1, `data_out`=0x77.
- Mid-stream reset and counter: pull `reset` low mid-byte while active -> outputs are 0 immediately. With `RX_BYTE_COUNT_EN`, 5 data bytes after relock -> `byte_count`=5.
